cim_cmd_sequencer: RTL and testbench

//  Sequences burst commands from the host onto the CIM array decoder input bus (op_code/addr/data_bank/data_in).

---
 rtl/cim_pkg.sv | 30 +++
 rtl/cim_addr_step.sv | 26 ++
 rtl/cim_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_cim_cmd_sequencer.sv | 357 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cim_pkg.sv
// Shared definitions for the CIM command path: opcodes, address field
// positions and the sequencer state encoding.
package cim_pkg;

  localparam logic [1:0] OP_MAC = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
  localparam logic [1:0] OP_QRY = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  localparam int ADDR_W  = 9;
  localparam int BANK_HI = 8;
  localparam int BANK_LO = 5;
  localparam int ROW_HI  = 4;
  localparam int ROW_LO  = 3;
  localparam int COL_HI  = 2;
  localparam int COL_LO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TURN  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  // Operations that read the array and therefore need a gap after a write burst.
  function automatic logic is_read_op(input logic [1:0] op);
    return (op == OP_MAC) || (op == OP_QRY);
  endfunction

endpackage

// File: rtl/cim_addr_step.sv
// Next-address computation for one beat. Column-stepping ops move to the
// next column; MAC moves to the next row, carrying into the bank field.
// The whole 9-bit address wraps modulo 512.
module cim_addr_step
  import cim_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [1:0]        op_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [5:0]        bank_row_inc;
  logic [ADDR_W-1:0] col_inc;

  // Field-aware increment; the carry out of the bank field is dropped (mod 512).
  always_comb begin
    bank_row_inc = {addr_i[BANK_HI:BANK_LO], addr_i[ROW_HI:ROW_LO]} + 6'd1;
    col_inc      = addr_i + 9'd1;
    case (op_i)
      OP_MAC:        addr_o = {bank_row_inc, addr_i[COL_HI:COL_LO]};
      OP_WR, OP_QRY: addr_o = col_inc;
      default:       addr_o = addr_i;
    endcase
  end

endmodule

// File: rtl/cim_cmd_sequencer.sv
// Expands host burst commands into per-cycle beats on the CIM decoder bus,
// inserting NOP bubbles on operand stalls, a turnaround gap between a write
// burst and a following read-type burst, and a completion pulse once the
// last beat has travelled through the decoder/array pipeline.
module cim_cmd_sequencer
  import cim_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int TURN_CYC = 1,
  parameter int RESP_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [8:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [31:0]      s_data,
  output logic [1:0]       op_code,
  output logic [8:0]       addr,
  output logic [15:0]      data_bank,
  output logic [15:0]      data_in,
  output logic             busy,
  output logic             done,
  output logic [1:0]       done_op
);

  // Counters count down to zero, so they hold (cycles - 1).
  localparam int TURN_W  = (TURN_CYC > 1) ? $clog2(TURN_CYC) : 1;
  localparam int DRAIN_W = (RESP_LAT > 1) ? $clog2(RESP_LAT) : 1;
  localparam logic [TURN_W-1:0]  TURN_LOAD  = TURN_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'((RESP_LAT > 0) ? RESP_LAT - 1 : 0);

  state_e             state_q, state_d;
  logic [1:0]         cur_op_q, cur_op_d;
  logic [8:0]         cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [TURN_W-1:0]  turn_cnt_q, turn_cnt_d;
  logic [DRAIN_W-1:0] drain_cnt_q, drain_cnt_d;
  logic               wr_last_q, wr_last_d;
  logic [1:0]         op_code_q, op_code_d;
  logic [8:0]         addr_q, addr_d;
  logic [15:0]        data_bank_q, data_bank_d;
  logic [15:0]        data_in_q, data_in_d;
  logic               done_q, done_d;
  logic [1:0]         done_op_q, done_op_d;
  logic [8:0]         addr_next;

  cim_addr_step u_addr_step (
    .addr_i (cur_addr_q),
    .op_i   (cur_op_q),
    .addr_o (addr_next)
  );

  // Next-state, counters and decoder bus; the bus idles at NOP unless a beat is taken.
  always_comb begin
    state_d     = state_q;
    cur_op_d    = cur_op_q;
    cur_addr_d  = cur_addr_q;
    cnt_d       = cnt_q;
    turn_cnt_d  = turn_cnt_q;
    drain_cnt_d = drain_cnt_q;
    wr_last_d   = wr_last_q;
    op_code_d   = OP_NOP;
    addr_d      = addr_q;
    data_bank_d = data_bank_q;
    data_in_d   = data_in_q;
    done_d      = 1'b0;
    done_op_d   = done_op_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          cur_op_d    = cmd_op;
          cur_addr_d  = cmd_addr;
          cnt_d       = cmd_len;
          turn_cnt_d  = TURN_LOAD;
          drain_cnt_d = DRAIN_LOAD;
          if (wr_last_q && (TURN_CYC != 0) && is_read_op(cmd_op)) begin
            state_d = ST_TURN;
          end else if (cmd_op == OP_NOP) begin
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_RUN;
          end
        end
      end

      ST_TURN: begin
        if (turn_cnt_q == '0) begin
          state_d   = ST_RUN;
          wr_last_d = 1'b0;
        end else begin
          turn_cnt_d = turn_cnt_q - TURN_W'(1);
        end
      end

      ST_RUN: begin
        if (s_valid) begin
          op_code_d   = cur_op_q;
          addr_d      = cur_addr_q;
          data_bank_d = s_data[15:0];
          data_in_d   = s_data[31:16];
          cur_addr_d  = addr_next;
          if (cnt_q == '0) begin
            state_d     = ST_DRAIN;
            wr_last_d   = (cur_op_q == OP_WR);
            drain_cnt_d = DRAIN_LOAD;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end

      ST_DRAIN: begin
        if (drain_cnt_q == '0) begin
          done_d    = 1'b1;
          done_op_d = cur_op_q;
          state_d   = ST_IDLE;
        end else begin
          drain_cnt_d = drain_cnt_q - DRAIN_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Command context, counters and registered decoder outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_op_q    <= OP_MAC;
      cur_addr_q  <= '0;
      cnt_q       <= '0;
      turn_cnt_q  <= '0;
      drain_cnt_q <= '0;
      wr_last_q   <= 1'b0;
      op_code_q   <= OP_NOP;
      addr_q      <= '0;
      data_bank_q <= '0;
      data_in_q   <= '0;
      done_q      <= 1'b0;
      done_op_q   <= OP_MAC;
    end else begin
      cur_op_q    <= cur_op_d;
      cur_addr_q  <= cur_addr_d;
      cnt_q       <= cnt_d;
      turn_cnt_q  <= turn_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      wr_last_q   <= wr_last_d;
      op_code_q   <= op_code_d;
      addr_q      <= addr_d;
      data_bank_q <= data_bank_d;
      data_in_q   <= data_in_d;
      done_q      <= done_d;
      done_op_q   <= done_op_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign s_ready   = (state_q == ST_RUN);
  assign busy      = (state_q != ST_IDLE);
  assign op_code   = op_code_q;
  assign addr      = addr_q;
  assign data_bank = data_bank_q;
  assign data_in   = data_in_q;
  assign done      = done_q;
  assign done_op   = done_op_q;

endmodule

// File: tb/tb_cim_cmd_sequencer.sv
// Self-checking bench for cim_cmd_sequencer: a command table drives bursts,
// expected beats and completions go into scoreboard queues, and a monitor
// compares them against the decoder bus and the done pulse.
module tb_cim_cmd_sequencer;

  localparam int LEN_W    = 8;
  localparam int TURN_CYC = 1;
  localparam int RESP_LAT = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [8:0]       cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic             s_valid;
  logic             s_ready;
  logic [31:0]      s_data;
  logic [1:0]       op_code;
  logic [8:0]       addr;
  logic [15:0]      data_bank;
  logic [15:0]      data_in;
  logic             busy;
  logic             done;
  logic [1:0]       done_op;

  cim_cmd_sequencer #(
    .LEN_W    (LEN_W),
    .TURN_CYC (TURN_CYC),
    .RESP_LAT (RESP_LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .op_code   (op_code),
    .addr      (addr),
    .data_bank (data_bank),
    .data_in   (data_in),
    .busy      (busy),
    .done      (done),
    .done_op   (done_op)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  op;
    logic [8:0]  addr;
    logic [31:0] data;
  } beat_t;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] nbeats;
  } done_t;

  typedef struct {
    logic [1:0] op;
    logic [8:0] addr;
    int         len;
    bit         toggle;
    int         turn;
  } vec_t;

  beat_t exp_q[$];
  done_t exp_done[$];

  int n_checks = 0;
  int n_errors = 0;
  int mcyc = 0;
  int ref_cyc = 0;
  int beats_seen = 0;
  logic acc_s;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference address step: columns advance by 1, MAC advances one row (+8), mod 512.
  function automatic logic [8:0] model_step(input logic [8:0] a, input logic [1:0] op);
    case (op)
      2'b00:   return a + 9'd8;
      2'b01:   return a + 9'd1;
      2'b10:   return a + 9'd1;
      default: return a;
    endcase
  endfunction

  // Monitor: compare every non-NOP bus cycle and every done pulse with the scoreboard.
  always @(posedge clk) begin
    acc_s = cmd_valid && cmd_ready && rst_n;
    #1;
    mcyc++;
    if (!rst_n) begin
      beats_seen = 0;
    end else begin
      if (acc_s) begin
        ref_cyc    = mcyc;
        beats_seen = 0;
      end
      if (op_code != 2'b11) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          beat_t eb;
          eb = exp_q.pop_front();
          chk("beat_op", 64'(op_code), 64'(eb.op));
          chk("beat_addr", 64'(addr), 64'(eb.addr));
          chk("beat_data", 64'({data_in, data_bank}), 64'(eb.data));
        end
        beats_seen++;
        ref_cyc = mcyc;
      end
      if (done) begin
        if (exp_done.size() == 0) begin
          fail_now("unexpected_done");
        end else begin
          done_t ed;
          ed = exp_done.pop_front();
          chk("done_op", 64'(done_op), 64'(ed.op));
          chk("done_beats", 64'(beats_seen), 64'(ed.nbeats));
          chk("done_latency", 64'(mcyc - ref_cyc), 64'(RESP_LAT));
        end
      end
    end
  end

  task automatic wait_ready();
    int w;
    w = 0;
    @(negedge clk);
    while (!cmd_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!cmd_ready) fail_now("cmd_ready_timeout");
  endtask

  // Issue one command, feed its operands, and check first-beat latency when streaming.
  task automatic run_cmd(input logic [1:0] op, input logic [8:0] a, input int len,
                         input bit toggle, input int exp_turn);
    int    nbeats, idx, cyc_rel, w, phase;
    bit    first_seen, will;
    logic [8:0]  ma;
    logic [31:0] d;
    done_t ed;
    nbeats = (op == 2'b11) ? 0 : len + 1;
    wait_ready();
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_len   = len[7:0];
    idx       = 0;
    ma        = a;
    phase     = 0;
    d         = $urandom();
    s_data    = d;
    s_valid   = (nbeats > 0);
    ed.op     = op;
    ed.nbeats = 16'(nbeats);
    exp_done.push_back(ed);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    cyc_rel    = 0;
    first_seen = 0;
    w          = 0;
    while (busy && w < 5000) begin
      @(negedge clk);
      if (idx < nbeats) begin
        s_data  = d;
        s_valid = toggle ? (phase % 2 == 0) : 1'b1;
      end else begin
        s_valid = 1'b0;
      end
      will = s_valid && s_ready;
      if (s_ready) phase++;
      @(posedge clk);
      cyc_rel++;
      w++;
      if (will) begin
        exp_q.push_back({op, ma, d});
        ma = model_step(ma, op);
        idx++;
        d = $urandom();
      end
      #1;
      if (!toggle && !first_seen && nbeats > 0 && op_code != 2'b11) begin
        first_seen = 1;
        chk("first_beat_latency", 64'(cyc_rel), 64'(1 + exp_turn));
      end
    end
    if (busy) fail_now("burst_timeout");
    if (!toggle && nbeats > 0 && !first_seen) fail_now("first_beat_missing");
    s_valid = 1'b0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{op: 2'b01, addr: 9'h1FE, len: 3,   toggle: 0, turn: 0};
    vecs[1] = '{op: 2'b00, addr: 9'h020, len: 3,   toggle: 0, turn: 1};
    vecs[2] = '{op: 2'b10, addr: 9'h005, len: 4,   toggle: 1, turn: 0};
    vecs[3] = '{op: 2'b01, addr: 9'h010, len: 1,   toggle: 0, turn: 0};
    vecs[4] = '{op: 2'b10, addr: 9'h1FF, len: 2,   toggle: 0, turn: 1};
    vecs[5] = '{op: 2'b00, addr: 9'h1F8, len: 255, toggle: 0, turn: 0};
    vecs[6] = '{op: 2'b01, addr: 9'h0AA, len: 0,   toggle: 0, turn: 0};
    vecs[7] = '{op: 2'b00, addr: 9'h000, len: 0,   toggle: 0, turn: 1};
    vecs[8] = '{op: 2'b11, addr: 9'h000, len: 7,   toggle: 0, turn: 0};

    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_addr  = '0;
    cmd_len   = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_op_code", 64'(op_code), 64'(2'b11));
    chk("rst_addr", 64'(addr), 64'd0);
    chk("rst_data_bank", 64'(data_bank), 64'd0);
    chk("rst_data_in", 64'(data_in), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_done_op", 64'(done_op), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_cmd(vecs[i].op, vecs[i].addr, vecs[i].len, vecs[i].toggle, vecs[i].turn);
      $display("cmd %0d op=%0d addr=0x%03h len=%0d done, checks so far %0d", i,
               vecs[i].op, vecs[i].addr, vecs[i].len, n_checks);
    end

    // Reset during beat 2 of an 8-beat write: no done, write history forgotten.
    begin
      int   nb;
      bit   will;
      logic [8:0]  ma;
      logic [31:0] d;
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = 2'b01;
      cmd_addr  = 9'h040;
      cmd_len   = 8'd7;
      ma        = 9'h040;
      d         = $urandom();
      s_data    = d;
      s_valid   = 1'b1;
      nb        = 0;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      for (int k = 0; k < 20 && nb < 2; k++) begin
        @(negedge clk);
        s_data = d;
        will = s_valid && s_ready;
        @(posedge clk);
        if (will) begin
          exp_q.push_back({2'b01, ma, d});
          ma = model_step(ma, 2'b01);
          d  = $urandom();
          nb++;
        end
        #1;
      end
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_op_code", 64'(op_code), 64'(2'b11));
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_beats_left", 64'(exp_q.size()), 64'd0);
      s_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      $display("mid-burst reset sequence complete");
    end
    run_cmd(2'b00, 9'h080, 2, 0, 0);
    $display("MAC after reset complete");

    // Reserved op with cmd_valid held: no operands taken, nothing accepted while busy.
    begin
      int    w;
      done_t ed;
      wait_ready();
      cmd_valid = 1'b1;
      cmd_op    = 2'b11;
      cmd_addr  = 9'h000;
      cmd_len   = 8'd0;
      s_valid   = 1'b1;
      ed.op     = 2'b11;
      ed.nbeats = 16'd0;
      exp_done.push_back(ed);
      @(posedge clk);
      #1;
      w = 0;
      while (busy && w < 20) begin
        chk("held_cmd_ready", 64'(cmd_ready), 64'd0);
        chk("held_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        w++;
      end
      if (busy) fail_now("held_busy_timeout");
      chk("held_idle_ready", 64'(cmd_ready), 64'd1);
      exp_done.push_back(ed);
      @(posedge clk);
      #1;
      chk("held_accept_at_idle", 64'(busy), 64'd1);
      cmd_valid = 1'b0;
      w = 0;
      while (busy && w < 20) begin
        chk("held2_s_ready", 64'(s_ready), 64'd0);
        @(posedge clk);
        #1;
        w++;
      end
      if (busy) fail_now("held2_busy_timeout");
      s_valid = 1'b0;
      repeat (4) @(posedge clk);
      $display("reserved-op held-valid sequence complete");
    end

    #1;
    chk("beats_outstanding", 64'(exp_q.size()), 64'd0);
    chk("dones_outstanding", 64'(exp_done.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout (t=%0t)", $time);
    $fatal(1, "global timeout");
  end

endmodule
